// File: rtl/child_rr_scheduler.sv
// child_rr_scheduler: round-robin owner of one shared resource among N_CHILD sibling instances.
// Flow per grant: IDLE -> GRANT (one-hot gnt) -> RELEASE (one-cycle gap) -> IDLE.
// All outputs come straight from flops; req/done never reach an output combinationally.
// Optional feature: define CHILD_SCHED_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles
// and pulse timeout; without it MAX_HOLD is unused and timeout is tied low.

module child_rr_scheduler #(
   parameter int unsigned N_CHILD  = 5,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned ID_W     = $clog2(N_CHILD)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_CHILD-1:0] req,
   input  logic [N_CHILD-1:0] done,
   output logic [N_CHILD-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               busy,
   output logic               timeout
);

   // Elaboration-time sanity on the configuration.
   if (N_CHILD < 2 || MAX_HOLD < 2 || ID_W < $clog2(N_CHILD)) begin : g_param_check
      $error("child_rr_scheduler: need N_CHILD >= 2, MAX_HOLD >= 2, ID_W >= clog2(N_CHILD)");
   end

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StRelease = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [N_CHILD-1:0]   gnt_q, gnt_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
   logic                 busy_q, busy_d;

   logic [ID_W-1:0]      pick_id;
   logic                 pick_found;
   logic                 owner_release;
   logic                 hold_expired;
   logic                 revoke;

   // Pick the first requester at or after ptr, wrapping modulo N_CHILD.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      pick_id    = '0;
      pick_found = 1'b0;
      for (int unsigned i = 0; i < N_CHILD; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= N_CHILD) begin
            idx = idx - N_CHILD;
         end
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick_id    = ID_W'(idx);
         end
      end
   end

   // Only the owner's done and req bits matter while granted.
   assign owner_release = done[gnt_id_q] | ~req[gnt_id_q];
   assign revoke        = (state_q == StGrant) & (owner_release | hold_expired);

`ifdef CHILD_SCHED_TIMEOUT_EN
   localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             timeout_q, timeout_d;

   // hold_q counts completed GRANT cycles, so expiry is checked one short of MAX_HOLD.
   assign hold_expired = (hold_q == HoldW'(MAX_HOLD - 1));

   // Hold counter: cleared while idle (the only way into GRANT), counts up while granted.
   always_comb begin
      hold_d    = hold_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle:  hold_d = '0;
         StGrant: begin
            hold_d = hold_q + HoldW'(1);
            // A real release in the same cycle wins over the forced one.
            timeout_d = hold_expired & ~owner_release;
         end
         default: hold_d = hold_q;
      endcase
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

   // Next-state and next-output computation for the grant FSM.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      busy_d      = busy_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               state_d     = StGrant;
               gnt_d       = N_CHILD'(1) << pick_id;
               gnt_valid_d = 1'b1;
               gnt_id_d    = pick_id;
               busy_d      = 1'b1;
            end
         end
         StGrant: begin
            if (revoke) begin
               state_d     = StRelease;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               busy_d      = 1'b1;
               // gnt_id keeps the last owner; the pointer moves just past it.
               ptr_d       = (gnt_id_q == ID_W'(N_CHILD - 1)) ? '0 : gnt_id_q + ID_W'(1);
            end
         end
         StRelease: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: begin
            state_d     = StIdle;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State, pointer and registered outputs; reset drops everything without a RELEASE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;

   // Exclusivity and output consistency.
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_valid_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
   a_busy_cover:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> busy);

endmodule
